// File: rtl/mips_mem_pkg.sv
// Shared constants for the data-memory responder: I/O page offsets and STATUS layout.
package mips_mem_pkg;

  localparam logic [31:0] OFF_COUNTER = 32'h0000_0000;
  localparam logic [31:0] OFF_TXDATA  = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;

  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_ERR    = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_OCC_LO = 8;
  localparam int ST_OCC_HI = 15;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
// Head is registered (no bypass); head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign push_drop = push & ~push_ok;
  assign head      = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO page (cycle counter, console TX FIFO, status).
// Reads are combinational from current state; writes take effect on the clock edge.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          RAM_AW    = $clog2(MEM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [31:0] A_COUNTER = IO_BASE + OFF_COUNTER;
  localparam logic [31:0] A_TXDATA  = IO_BASE + OFF_TXDATA;
  localparam logic [31:0] A_STATUS  = IO_BASE + OFF_STATUS;

  logic [31:0]     ram_q [MEM_WORDS];
  logic [31:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            ram_sel, cnt_sel, txd_sel, st_sel, unmapped;
  logic [RAM_AW-1:0] ram_idx;
  logic            fifo_full, fifo_empty, fifo_drop, tx_pop;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     status;
  logic [1:0]      unused_addr_lsb;

  assign unused_addr_lsb = addr[1:0];

  assign ram_sel  = (addr < RAM_BYTES);
  assign cnt_sel  = (addr[31:2] == A_COUNTER[31:2]);
  assign txd_sel  = (addr[31:2] == A_TXDATA[31:2]);
  assign st_sel   = (addr[31:2] == A_STATUS[31:2]);
  assign unmapped = ~(ram_sel | cnt_sel | txd_sel | st_sel);
  assign ram_idx  = addr[RAM_AW+1:2];

  assign tx_valid = ~fifo_empty;
  assign tx_pop   = tx_valid & tx_ready;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_write & txd_sel),
    .push_data (write_data[7:0]),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .push_drop (fifo_drop)
  );

  always_comb begin
    status                      = '0;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_FULL]             = fifo_full;
    status[ST_ERR]              = err_q;
    status[ST_OVF]              = ovf_q;
    status[ST_OCC_HI:ST_OCC_LO] = 8'(fifo_count);
  end

  always_comb begin
    read_data = '0;
    if (ram_sel)      read_data = ram_q[ram_idx];
    else if (cnt_sel) read_data = cnt_q;
    else if (st_sel)  read_data = status;
  end

  // A store to the counter takes priority over the free-running increment.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    err_d = err_q;
    ovf_d = ovf_q;
    if (mem_write && cnt_sel) cnt_d = write_data;
    if (mem_write && st_sel && write_data[ST_ERR]) err_d = 1'b0;
    if (mem_write && st_sel && write_data[ST_OVF]) ovf_d = 1'b0;
    if (mem_write && unmapped) err_d = 1'b1;
    if (fifo_drop)             ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) ram_q[i] <= '0;
    end else if (mem_write && ram_sel) begin
      ram_q[ram_idx] <= write_data;
    end
  end

endmodule
